// File: rtl/raster_mem_ctrl.sv
// Frame-buffer / z-buffer controller: rasterizer write ports, clear engine and scan-out read.
// Optional macro ZB_FORWARD_EN: forward same-cycle rasterizer z-write data to the z-read port.
module raster_mem_ctrl #(
    parameter int          H_RES       = 320,
    parameter int          V_RES       = 240,
    parameter int          ADDR_W      = 17,
    parameter logic [11:0] CLEAR_COLOR = 12'h000,
    parameter logic [7:0]  CLEAR_DEPTH = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear_start,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic              o_rast_ready,
    input  logic [ADDR_W-1:0] i_zb_r_addr,
    output logic [7:0]        o_zb_r_data,
    input  logic              i_zb_w_we,
    input  logic [ADDR_W-1:0] i_zb_w_addr,
    input  logic [7:0]        i_zb_w_data,
    input  logic              i_fb_we,
    input  logic [ADDR_W-1:0] i_fb_addr,
    input  logic [11:0]       i_fb_pixel,
    input  logic [ADDR_W-1:0] i_scan_addr,
    output logic [11:0]       o_scan_pixel,
    output logic              o_drop_err
);

    localparam int                DEPTH   = H_RES * V_RES;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [11:0] r_fbuf [0:DEPTH-1];
    logic [7:0]  r_zbuf [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_zb_r_data;
    logic [11:0]       r_scan_pixel;
    logic              r_drop_err;

    logic              w_busy;
    logic              w_start;
    logic              w_fb_in, w_zw_in, w_zr_in, w_scan_in;
    logic              w_fb_we, w_zb_we;
    logic [ADDR_W-1:0] w_fb_waddr, w_zb_waddr;
    logic [11:0]       w_fb_wdata;
    logic [7:0]        w_zb_wdata;
    logic              w_err;

    assign w_busy  = (r_state == S_CLEAR);
    assign w_start = (r_state == S_IDLE) && i_clear_start;

    assign w_fb_in   = {1'b0, i_fb_addr}   < DEPTH_X;
    assign w_zw_in   = {1'b0, i_zb_w_addr} < DEPTH_X;
    assign w_zr_in   = {1'b0, i_zb_r_addr} < DEPTH_X;
    assign w_scan_in = {1'b0, i_scan_addr} < DEPTH_X;

    // The clear engine owns both write ports for the whole CLEAR state.
    assign w_fb_we    = w_busy | (i_fb_we & w_fb_in);
    assign w_fb_waddr = w_busy ? r_cnt : i_fb_addr;
    assign w_fb_wdata = w_busy ? CLEAR_COLOR : i_fb_pixel;
    assign w_zb_we    = w_busy | (i_zb_w_we & w_zw_in);
    assign w_zb_waddr = w_busy ? r_cnt : i_zb_w_addr;
    assign w_zb_wdata = w_busy ? CLEAR_DEPTH : i_zb_w_data;

    assign w_err = (w_busy & (i_fb_we | i_zb_w_we))
                 | (i_fb_we & ~w_fb_in)
                 | (i_zb_w_we & ~w_zw_in)
                 | ~w_zr_in;

`ifdef ZB_FORWARD_EN
    logic w_fwd;
    assign w_fwd = (r_state == S_IDLE) && i_zb_w_we && w_zw_in && (i_zb_w_addr == i_zb_r_addr);
`endif

    // NOTE: memory arrays carry no reset so they map onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_fb_we) r_fbuf[w_fb_waddr] <= w_fb_wdata;
        if (w_zb_we) r_zbuf[w_zb_waddr] <= w_zb_wdata;
    end

    // NOTE: non-blocking reads make a same-cycle write return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zb_r_data  <= '0;
            r_scan_pixel <= '0;
        end else begin
            if (!w_zr_in)      r_zb_r_data <= CLEAR_DEPTH;
`ifdef ZB_FORWARD_EN
            else if (w_fwd)    r_zb_r_data <= i_zb_w_data;
`endif
            else               r_zb_r_data <= r_zbuf[i_zb_r_addr];

            r_scan_pixel <= w_scan_in ? r_fbuf[i_scan_addr] : CLEAR_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= (w_start ? 1'b0 : r_drop_err) | w_err;
            case (r_state)
                S_IDLE: begin
                    if (i_clear_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_clear_busy = w_busy;
    assign o_clear_done = (r_state == S_DONE);
    assign o_rast_ready = ~w_busy;
    assign o_zb_r_data  = r_zb_r_data;
    assign o_scan_pixel = r_scan_pixel;
    assign o_drop_err   = r_drop_err;

endmodule

// File: tb/tb_raster_mem_ctrl.sv
// Directed bench for raster_mem_ctrl on a reduced 20x12 frame so every clear stays short.
// Clear colour is overridden to a non-zero value so cleared words are distinguishable from power-up contents.
module tb_raster_mem_ctrl;

    localparam int          H      = 20;
    localparam int          V      = 12;
    localparam int          N      = H * V;      // 240 pixels
    localparam int          AW     = 8;
    localparam logic [11:0] CCOL   = 12'h123;
    localparam logic [7:0]  CDEP   = 8'hFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clear_start = 1'b0;
    logic          o_clear_busy, o_clear_done, o_rast_ready;
    logic [AW-1:0] i_zb_r_addr = '0;
    logic [7:0]    o_zb_r_data;
    logic          i_zb_w_we = 1'b0;
    logic [AW-1:0] i_zb_w_addr = '0;
    logic [7:0]    i_zb_w_data = '0;
    logic          i_fb_we = 1'b0;
    logic [AW-1:0] i_fb_addr = '0;
    logic [11:0]   i_fb_pixel = '0;
    logic [AW-1:0] i_scan_addr = '0;
    logic [11:0]   o_scan_pixel;
    logic          o_drop_err;

    int n_checks = 0;
    int n_fails  = 0;

    raster_mem_ctrl #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .CLEAR_COLOR(CCOL), .CLEAR_DEPTH(CDEP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_clear_start(i_clear_start), .o_clear_busy(o_clear_busy),
        .o_clear_done(o_clear_done), .o_rast_ready(o_rast_ready),
        .i_zb_r_addr(i_zb_r_addr), .o_zb_r_data(o_zb_r_data),
        .i_zb_w_we(i_zb_w_we), .i_zb_w_addr(i_zb_w_addr), .i_zb_w_data(i_zb_w_data),
        .i_fb_we(i_fb_we), .i_fb_addr(i_fb_addr), .i_fb_pixel(i_fb_pixel),
        .i_scan_addr(i_scan_addr), .o_scan_pixel(o_scan_pixel), .o_drop_err(o_drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fb_write(input logic [AW-1:0] a, input logic [11:0] p);
        i_fb_we = 1'b1; i_fb_addr = a; i_fb_pixel = p;
        tick();
        i_fb_we = 1'b0;
    endtask

    task automatic zb_write(input logic [AW-1:0] a, input logic [7:0] d);
        i_zb_w_we = 1'b1; i_zb_w_addr = a; i_zb_w_data = d;
        tick();
        i_zb_w_we = 1'b0;
    endtask

    task automatic scan_read(input string tag, input logic [AW-1:0] a, input logic [11:0] exp);
        i_scan_addr = a;
        tick();
        check(tag, 32'(o_scan_pixel), 32'(exp));
    endtask

    task automatic z_read(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        i_zb_r_addr = a;
        tick();
        check(tag, 32'(o_zb_r_data), 32'(exp));
        i_zb_r_addr = '0;
    endtask

    // Start a clear, optionally poking a rasterizer write or a second start at given clear cycles.
    task automatic run_clear(input int inj_at, input int restart_at);
        int n;
        i_clear_start = 1'b1;
        tick();
        i_clear_start = 1'b0;
        check("clr_busy_after_start", 32'(o_clear_busy), 32'd1);
        check("clr_ready_low", 32'(o_rast_ready), 32'd0);
        check("clr_err_cleared", 32'(o_drop_err), 32'd0);
        n = 0;
        while (o_clear_busy && n < N + 10) begin
            if (n == inj_at) begin
                i_fb_we = 1'b1; i_fb_addr = 8'd5; i_fb_pixel = 12'hFFF;
            end
            if (n == restart_at) i_clear_start = 1'b1;
            tick();
            i_fb_we = 1'b0;
            i_clear_start = 1'b0;
            if (o_clear_busy || o_clear_done) check("clr_no_early_done", 32'(o_clear_done && o_clear_busy), 32'd0);
            n++;
        end
        check("clr_busy_cycles", 32'(n), 32'(N));
        check("clr_done_pulse", 32'(o_clear_done), 32'd1);
        check("clr_err_flag", 32'(o_drop_err), 32'(inj_at >= 0));
        tick();
        check("clr_done_low", 32'(o_clear_done), 32'd0);
        check("clr_ready_back", 32'(o_rast_ready), 32'd1);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_busy", 32'(o_clear_busy), 32'd0);
        check("rst_done", 32'(o_clear_done), 32'd0);
        check("rst_ready", 32'(o_rast_ready), 32'd1);
        check("rst_zdata", 32'(o_zb_r_data), 32'd0);
        check("rst_scan", 32'(o_scan_pixel), 32'd0);
        check("rst_err", 32'(o_drop_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // First clear overwrites pre-existing content
        fb_write(8'd5, 12'hF0A);
        zb_write(8'd120, 8'h11);
        run_clear(-1, -1);
        z_read("clr_z_first", 8'd0, CDEP);
        z_read("clr_z_mid", 8'd120, CDEP);
        z_read("clr_z_last", 8'(N - 1), CDEP);
        scan_read("clr_scan_first", 8'd0, CCOL);
        scan_read("clr_scan_5", 8'd5, CCOL);
        scan_read("clr_scan_last", 8'(N - 1), CCOL);

        // Rasterizer writes, including both ports in one cycle
        fb_write(8'd100, 12'hF0A);
        scan_read("rast_fb_100", 8'd100, 12'hF0A);
        zb_write(8'd100, 8'h42);
        z_read("rast_zb_100", 8'd100, 8'h42);
        i_fb_we = 1'b1; i_fb_addr = 8'd7; i_fb_pixel = 12'h0C3;
        i_zb_w_we = 1'b1; i_zb_w_addr = 8'd9; i_zb_w_data = 8'h5E;
        tick();
        i_fb_we = 1'b0; i_zb_w_we = 1'b0;
        scan_read("dual_fb_7", 8'd7, 12'h0C3);
        z_read("dual_zb_9", 8'd9, 8'h5E);
        check("rast_no_err", 32'(o_drop_err), 32'd0);

        // Same-cycle z read/write on a cleared word
        i_zb_w_we = 1'b1; i_zb_w_addr = 8'd200; i_zb_w_data = 8'h33; i_zb_r_addr = 8'd200;
        tick();
        i_zb_w_we = 1'b0;
`ifdef ZB_FORWARD_EN
        check("raw_same_cycle", 32'(o_zb_r_data), 32'h33);
`else
        check("raw_same_cycle", 32'(o_zb_r_data), 32'hFF);
`endif
        z_read("raw_after", 8'd200, 8'h33);

        // Out-of-range scan does not flag; out-of-range z write does
        scan_read("oor_scan", 8'd240, CCOL);
        check("oor_scan_no_err", 32'(o_drop_err), 32'd0);
        zb_write(8'd240, 8'h10);
        check("oor_zw_err", 32'(o_drop_err), 32'd1);
        z_read("oor_zr", 8'd240, CDEP);
        z_read("oor_no_alias_0", 8'd0, CDEP);
        z_read("oor_keep_100", 8'd100, 8'h42);

        // Clear with a write dropped at cycle 10 and an ignored restart at cycle 50
        run_clear(10, 50);
        scan_read("drop_fb_5", 8'd5, CCOL);
        z_read("drop_zb_100", 8'd100, CDEP);
        check("drop_err_sticky", 32'(o_drop_err), 32'd1);

        // Reset in the middle of a clear
        fb_write(8'd50, 12'h0AA);
        fb_write(8'd150, 12'h777);
        i_clear_start = 1'b1;
        tick();
        i_clear_start = 1'b0;
        check("midrst_err_cleared", 32'(o_drop_err), 32'd0);
        repeat (100) tick();
        check("midrst_busy_before", 32'(o_clear_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_async", 32'(o_clear_busy), 32'd0);
        check("midrst_ready_async", 32'(o_rast_ready), 32'd1);
        check("midrst_done_low", 32'(o_clear_done), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_idle_done", 32'(o_clear_done), 32'd0);
            check("midrst_idle_busy", 32'(o_clear_busy), 32'd0);
        end
        scan_read("midrst_partial_50", 8'd50, CCOL);
        scan_read("midrst_partial_150", 8'd150, 12'h777);
        run_clear(-1, -1);
        scan_read("midrst_final_150", 8'd150, CCOL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
